// File: rtl/fmul_arbiter.sv
// Two-requester round-robin front end for a shared pipelined floating-point multiplier.
// Optional per-requester issue counters are enabled by defining FMUL_ARB_STATS_EN.
module fmul_arbiter #(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r0_b,
    input  logic [1:0]       r0_rm,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r1_b,
    input  logic [1:0]       r1_rm,
    output logic [31:0]      f_a,
    output logic [31:0]      f_b,
    output logic [1:0]       f_rm,
    output logic             f_e,
    input  logic [31:0]      f_s,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_id,
    output logic [31:0]      o_s
`ifdef FMUL_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    typedef enum logic [0:0] {
        LAST_R0 = 1'b0,
        LAST_R1 = 1'b1
    } last_e;

    last_e          state_r;
    last_e          state_nxt_s;
    logic           gnt0_s;
    logic           gnt1_s;
    logic           issue_s;
    logic           stall_s;
    logic           o_valid_s;
    logic [LAT-1:0] vld_r;
    logic [LAT-1:0] id_r;

    if (LAT < 1 || CNT_W < 1) begin : g_bad_param
        $error("fmul_arbiter: LAT and CNT_W must both be at least 1");
    end

    // Reset masks the output so a flushed tag is never seen, even in the reset cycle itself.
    assign o_valid_s = vld_r[LAT-1] & ~reset;
    assign stall_s   = o_valid_s & ~o_ready;
    assign issue_s   = gnt0_s | gnt1_s;

    assign f_e      = ~stall_s;
    assign o_valid  = o_valid_s;
    assign o_id     = id_r[LAT-1];
    assign o_s      = f_s;
    assign r0_ready = gnt0_s;
    assign r1_ready = gnt1_s;

    // Last-grant state register; after reset r0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= LAST_R1;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next last-grant: moves only on a handshake.
    always_comb begin
        state_nxt_s = state_r;
        if (gnt0_s) begin
            state_nxt_s = LAST_R0;
        end else if (gnt1_s) begin
            state_nxt_s = LAST_R1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Grant outputs: nothing is accepted while stalled or in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset || stall_s) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case ({r1_valid, r0_valid})
                2'b01: gnt0_s = 1'b1;
                2'b10: gnt1_s = 1'b1;
                2'b11: begin
                    if (state_r == LAST_R1) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Operand mux towards the multiplier; zeros when idle.
    always_comb begin
        f_a  = 32'h0000_0000;
        f_b  = 32'h0000_0000;
        f_rm = 2'b00;
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                f_a  = r0_a;
                f_b  = r0_b;
                f_rm = r0_rm;
            end
            2'b10: begin
                f_a  = r1_a;
                f_b  = r1_b;
                f_rm = r1_rm;
            end
            default: begin
                f_a  = 32'h0000_0000;
                f_b  = 32'h0000_0000;
                f_rm = 2'b00;
            end
        endcase
    end

    // Tag pipe tracks the multiplier stages; idle cycles travel as bubbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_r <= {LAT{1'b0}};
            id_r  <= {LAT{1'b0}};
        end else if (!stall_s) begin
            vld_r[0] <= issue_s;
            id_r[0]  <= gnt1_s;
            for (int k = 1; k < LAT; k++) begin
                vld_r[k] <= vld_r[k-1];
                id_r[k]  <= id_r[k-1];
            end
        end else begin
            vld_r <= vld_r;
            id_r  <= id_r;
        end
    end

`ifdef FMUL_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Saturating handshake counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (gnt0_s && (cnt0_r != CNT_MAX)) begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end else begin
                cnt0_r <= cnt0_r;
            end
            if (gnt1_s && (cnt1_r != CNT_MAX)) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`else
`endif

endmodule
